// File: rtl/config_loader_if.sv
// Valid/ready word stream carrying configuration words into the loader.
interface config_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/config_loader.sv
// Shifts streamed configuration words into a wide config bus and
// holds the logic column in reset until the bitstream is complete.
module config_loader #(
  parameter int CONFIG_WIDTH = 5152,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  config_loader_if.slave          stream,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_done,
  output logic                    busy,
  output logic                    fabric_nreset
);

  localparam int NUM_WORDS =
    (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int SR_W  = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SR_W-1:0]  sr;
  logic             shift;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // first word ends up in the LSBs once the load completes
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sr <= '0;
    end else if (shift) begin
      sr <= {stream.data_in, sr[SR_W-1:WORD_WIDTH]};
    end
  end

  always_comb begin
    state_d           = state;
    cnt_d             = cnt;
    shift             = 1'b0;
    stream.data_ready = 1'b0;
    busy              = 1'b0;
    config_done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        stream.data_ready = 1'b1;
        busy              = 1'b1;
        // start wins over a coincident beat
        if (start) begin
          cnt_d = '0;
        end else if (stream.data_valid) begin
          shift = 1'b1;
          cnt_d = cnt + 1'b1;
          if (cnt == LAST) state_d = DONE;
        end
      end
      DONE: begin
        config_done = 1'b1;
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign fabric_nreset = (state == DONE);
  assign config_out    = sr[CONFIG_WIDTH-1:0];

endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader with a word-array
// reference model of the expected configuration bus.
module tb_config_loader;

  localparam int CW = 5152;
  localparam int WW = 32;
  localparam int NW = 161;

  logic          clock = 1'b0;
  logic          nreset;
  logic          start;
  logic [CW-1:0] config_out;
  logic          config_done;
  logic          busy;
  logic          fabric_nreset;

  config_loader_if #(.WORD_WIDTH(WW)) s ();

  config_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH  (WW)
  ) dut (
    .clock        (clock),
    .nreset       (nreset),
    .start        (start),
    .stream       (s),
    .config_out   (config_out),
    .config_done  (config_done),
    .busy         (busy),
    .fabric_nreset(fabric_nreset)
  );

  always #5 clock = ~clock;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [WW-1:0] wv [NW];
  logic [CW-1:0] exp_cfg;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic build_exp();
    for (int k = 0; k < NW; k++)
      exp_cfg[k*WW +: WW] = wv[k];
  endtask

  function automatic int first_bad();
    for (int k = 0; k < NW; k++)
      if (config_out[k*WW +: WW] !== exp_cfg[k*WW +: WW])
        return k;
    return -1;
  endfunction

  task automatic set_k_words();
    for (int k = 0; k < NW; k++) wv[k] = WW'(k);
  endtask

  task automatic set_rand_words();
    for (int k = 0; k < NW; k++) wv[k] = WW'($urandom);
  endtask

  // gap: 0 back-to-back, 1 alternating, 2 random
  task automatic load(input int gap, input bit do_start,
                      output int bcnt);
    int beats = 0;
    int guard = 0;
    int bad   = 0;
    bit v;
    bcnt = 0;
    if (do_start) begin
      start = 1'b1;
      s.data_valid = 1'b0;
      cyc();
      start = 1'b0;
    end
    while (beats < NW && guard < 4000) begin
      if (gap == 0)      v = 1'b1;
      else if (gap == 1) v = (guard % 2 == 0);
      else               v = 1'($urandom_range(0, 1));
      s.data_valid = v;
      s.data_in    = v ? wv[beats] : WW'($urandom);
      if (busy === 1'b1) bcnt++;
      if (s.data_ready !== 1'b1 || config_done !== 1'b0 ||
          fabric_nreset !== 1'b0)
        bad++;
      cyc();
      if (v) beats++;
      guard++;
    end
    s.data_valid = 1'b0;
    n_tests++;
    if (bad != 0 || beats != NW) begin
      n_fail++;
      $display("FAIL load_phase bad_cycles=%0d beats=%0d req 0/%0d",
               bad, beats, NW);
    end
    n_tests++;
    if ({config_done, fabric_nreset, busy, s.data_ready}
        !== 4'b1100) begin
      n_fail++;
      $display("FAIL done_latency done/fnr/busy/rdy=%b req 1100",
               {config_done, fabric_nreset, busy, s.data_ready});
    end
  endtask

  task automatic cmp_cfg(input string name);
    int fb;
    n_tests++;
    fb = first_bad();
    if (fb != -1) begin
      n_fail++;
      $display("FAIL %s word %0d got %h req %h", name, fb,
               config_out[fb*WW +: WW], exp_cfg[fb*WW +: WW]);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start        = 1'($urandom_range(0, 1));
      s.data_valid = 1'($urandom_range(0, 1));
      s.data_in    = WW'($urandom);
      cyc();
      n_tests++;
      if (config_out !== '0 || s.data_ready !== 1'b0 ||
          config_done !== 1'b0 || fabric_nreset !== 1'b0 ||
          busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d rdy=%b done=%b fnr=%b",
                 i, s.data_ready, config_done, fabric_nreset);
      end
    end
    start = 1'b0;
    s.data_valid = 1'b0;
    cyc();
    nreset = 1'b1;
    cyc();
  endtask

  task automatic test_ignore_idle();
    for (int i = 0; i < 5; i++) begin
      s.data_valid = 1'b1;
      s.data_in    = WW'($urandom);
      cyc();
    end
    n_tests++;
    if (config_out !== '0 || s.data_ready !== 1'b0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore rdy=%b busy=%b req 0 0",
               s.data_ready, busy);
    end
    s.data_valid = 1'b0;
  endtask

  task automatic test_full_load();
    int b;
    set_k_words();
    build_exp();
    load(0, 1'b1, b);
    cmp_cfg("full_load");
  endtask

  task automatic test_gapped();
    int b;
    set_k_words();
    build_exp();
    load(1, 1'b1, b);
    cmp_cfg("gapped_cfg");
    n_tests++;
    if (b != 321) begin
      n_fail++;
      $display("FAIL gapped_busy got %0d req 321", b);
    end
  endtask

  task automatic test_ignore_done();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      s.data_valid = 1'b1;
      s.data_in    = WW'($urandom);
      if (s.data_ready !== 1'b0) bad++;
      cyc();
    end
    s.data_valid = 1'b0;
    n_tests++;
    if (bad != 0 || config_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignore rdy_bad=%0d done=%b req 0 1",
               bad, config_done);
    end
    cmp_cfg("done_frozen");
  endtask

  task automatic test_restart();
    int b;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({config_done, fabric_nreset, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL restart_from_done done/fnr/busy=%b req 001",
               {config_done, fabric_nreset, busy});
    end
    for (int i = 0; i < 50; i++) begin
      s.data_valid = 1'b1;
      s.data_in    = '1;
      cyc();
    end
    start        = 1'b1;
    s.data_valid = 1'b1;
    s.data_in    = '1;
    cyc();
    start = 1'b0;
    set_k_words();
    build_exp();
    load(0, 1'b0, b);
    cmp_cfg("restart_midload");
  endtask

  task automatic test_reset_midload();
    int b;
    set_rand_words();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s.data_valid = 1'b1;
      s.data_in    = wv[i];
      cyc();
    end
    s.data_valid = 1'b0;
    nreset = 1'b0;
    #1;
    n_tests++;
    if (config_out !== '0 || s.data_ready !== 1'b0 ||
        busy !== 1'b0 || config_done !== 1'b0 ||
        fabric_nreset !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset rdy=%b busy=%b req 0 0",
               s.data_ready, busy);
    end
    cyc();
    nreset = 1'b1;
    cyc();
    set_k_words();
    build_exp();
    load(0, 1'b1, b);
    cmp_cfg("after_reset_load");
  endtask

  task automatic test_random();
    int b;
    for (int r = 0; r < 3; r++) begin
      set_rand_words();
      build_exp();
      load(2, 1'b1, b);
      cmp_cfg("random_load");
    end
  endtask

  initial begin
    nreset       = 1'b0;
    start        = 1'b0;
    s.data_valid = 1'b0;
    s.data_in    = '0;
    test_reset();
    test_ignore_idle();
    test_full_load();
    test_gapped();
    test_ignore_done();
    test_restart();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
